sram_ctrl: RTL and testbench
============================

Name: sram_ctrl

Overview:
- Responder end of the on-chip SRAM request interface (mem/rw/ready/addr/data2ram/data2fpga) used by the SRAM test and RGB write initiators.
- Accepts one byte read or write per handshake.
- Drives the external asynchronous 1M x 8 SRAM pins with registered, glitch-free strobes.
- Returns read data to the initiator.

Parameters:
- WAIT_CYC, 2, clk cycles oe_n/we_n held low per access; legal range 1..15; 2 meets 10 ns SRAM at 50 MHz with margin.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-low reset.
- mem  in  1  request strobe; sampled only while ready=1.
- rw  in  1  1=read, 0=write; sampled with mem.
- addr  in  20  byte address; sampled with mem.
- data2ram  in  8  write data; sampled with mem.
- ready  out  1  controller can accept a request this cycle.
- data2fpga  out  8  last read byte; held until next read completes.
- sram_addr  out  20  address to SRAM pins.
- sram_dq_o  out  8  data driven to SRAM.
- sram_dq_i  in  8  data from SRAM.
- sram_dq_oe  out  1  1=FPGA drives DQ.
- sram_ce_n  out  1  chip enable, active-low.
- sram_oe_n  out  1  output enable, active-low.
- sram_we_n  out  1  write enable, active-low.

Behaviour:
- Reset (rst=0, asynchronous) puts the FSM in IDLE and sets outputs:
  - ready=1, data2fpga=0, sram_addr=0, sram_dq_o=0, sram_dq_oe=0, sram_ce_n=1, sram_oe_n=1, sram_we_n=1.
  - Wait counter cleared.
- Reset mid-access aborts immediately. A partial write may corrupt only the addressed byte.
- All SRAM pin outputs and ready are registered; no combinational path from inputs to pins.
- FSM states: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, TURN (TURN is used only with the optional feature).
- IDLE:
  - ready=1. On mem=1, latch addr, rw and data2ram.
  - rw=1 -> RD. rw=0 -> WR_SETUP.
  - mem=0 -> stay in IDLE, pins idle.
- RD, WAIT_CYC cycles:
  - ce_n=0, oe_n=0, we_n=1, dq_oe=0, ready=0, sram_addr=latched addr.
  - On the clock edge ending the last RD cycle, data2fpga <= sram_dq_i, then go to IDLE.
- WR_SETUP, 1 cycle: ce_n=0, we_n=1, oe_n=1, dq_oe=1, sram_dq_o=latched data.
- WR_PULSE, WAIT_CYC cycles: we_n=0; address and data stable.
- WR_HOLD, 1 cycle: we_n=1; dq_oe=1 and data held. Then go to IDLE.
- Latency, counted from the accept edge:
  - Read: ready low WAIT_CYC cycles; data2fpga valid the cycle ready returns high.
  - Write: ready low WAIT_CYC+2 cycles.
- mem asserted while ready=0 is ignored; there is no queue. The initiator must hold mem until it sees ready=1.
- Address and data are stable on the pins for the whole access. sram_addr keeps the last value while idle.
- The wait counter is 4 bits, counts down, and reloads on each state entry. There is no wrap-around.

Optional Feature:
- Macro SRAM_CTRL_B2B_EN.
- Defined:
  - ready is also 1 during the last RD cycle and during WR_HOLD.
  - A mem sampled then starts the next access on the following cycle, skipping IDLE.
  - read->read goes directly to RD.
  - write->write goes directly to WR_SETUP.
  - write->read goes directly to RD; dq_oe drops on the same edge that oe_n falls.
  - read->write inserts TURN for 1 cycle (ce_n=1, oe_n=1, dq_oe=0) before WR_SETUP, to avoid bus contention.
- Undefined: ready=1 only in IDLE, so there is at least one IDLE cycle between accesses.

Test Plan:
- Reset: rst=0 mid-write with WAIT_CYC=2 -> same cycle ce_n=1, we_n=1, dq_oe=0, ready=1, data2fpga=0.
- Single write: mem=1, rw=0, addr=20'hABCDE, data2ram=8'h5A -> ready low 4 cycles; we_n low exactly 2 cycles; sram_addr=ABCDE and dq_o=5A stable from WR_SETUP through WR_HOLD.
- Single read: SRAM model holds 8'hC3 at 20'h00001; read request -> oe_n low 2 cycles; data2fpga=C3 when ready rises 2 cycles after accept; value held through a following write.
- Ignored request: pulse mem during a write while ready=0 -> no extra access; pin sequence unchanged.
- Walking-ones address test: write then read back 8'hFF^i at 20'h1<<i for i=0..19 -> all 20 readbacks match; WAIT_CYC=1 and WAIT_CYC=4 runs both pass.
- With SRAM_CTRL_B2B_EN: read, write, read issued back-to-back ->
  - cycle counts: read 2, TURN 1, write 4, read 2.
  - no cycle has dq_oe=1 and oe_n=0 together.
  - without the macro, the same sequence shows one IDLE cycle between each access.

Source files
------------

// File: rtl/sram_ctrl.sv
// sram_ctrl: one byte read/write per mem/ready handshake onto an async 1M x 8 SRAM with registered strobes.
// Latency: read WAIT_CYC cycles, write WAIT_CYC+2; mem seen while ready=0 is dropped. Macro SRAM_CTRL_B2B_EN chains accesses.
module sram_ctrl #(
  parameter int WAIT_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem,
  input  logic        rw,
  input  logic [19:0] addr,
  input  logic [7:0]  data2ram,
  output logic        ready,
  output logic [7:0]  data2fpga,
  output logic [19:0] sram_addr,
  output logic [7:0]  sram_dq_o,
  input  logic [7:0]  sram_dq_i,
  output logic        sram_dq_oe,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n
);

  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, TURN} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYC - 1);
`ifdef SRAM_CTRL_B2B_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  state_t     state;
  logic [3:0] cnt;
  logic [7:0] lat_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      lat_data   <= 8'd0;
      ready      <= 1'b1;
      data2fpga  <= 8'd0;
      sram_addr  <= 20'd0;
      sram_dq_o  <= 8'd0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
        end
        RD: begin
          if (cnt == 4'd0) begin
            data2fpga <= sram_dq_i;
            state     <= IDLE;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            ready     <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
            if (B2B && cnt == 4'd1) ready <= 1'b1;
          end
        end
        TURN: begin
          state      <= WR_SETUP;
          sram_ce_n  <= 1'b0;
          sram_dq_oe <= 1'b1;
          sram_dq_o  <= lat_data;
        end
        WR_SETUP: begin
          state     <= WR_PULSE;
          sram_we_n <= 1'b0;
          cnt       <= CNT_LOAD;
        end
        WR_PULSE: begin
          if (cnt == 4'd0) begin
            state     <= WR_HOLD;
            sram_we_n <= 1'b1;
            if (B2B) ready <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WR_HOLD: begin
          state      <= IDLE;
          sram_ce_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
          ready      <= 1'b1;
        end
        default: state <= IDLE;
      endcase

      // A request accepted from a chaining state overrides that state's wind-down above.
      if (mem && ready) begin
        sram_addr <= addr;
        lat_data  <= data2ram;
        if (rw) begin
          state      <= RD;
          cnt        <= CNT_LOAD;
          sram_ce_n  <= 1'b0;
          sram_oe_n  <= 1'b0;
          sram_we_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
          ready      <= B2B && (WAIT_CYC == 1);
        end else if (state == RD) begin
          // read->write: park the bus one cycle so the SRAM releases DQ first
          state      <= TURN;
          sram_ce_n  <= 1'b1;
          sram_oe_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
          ready      <= 1'b0;
        end else begin
          state      <= WR_SETUP;
          sram_ce_n  <= 1'b0;
          sram_oe_n  <= 1'b1;
          sram_we_n  <= 1'b1;
          sram_dq_oe <= 1'b1;
          sram_dq_o  <= data2ram;
          ready      <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: three instances (WAIT_CYC 2, 1, 4) each with its own async SRAM model.
module tb_sram_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #10 clk = ~clk;

  logic [2:0]  mem_v = 3'b000;
  logic        rw = 1'b0;
  logic [19:0] addr = 20'd0;
  logic [7:0]  data2ram = 8'd0;

  logic [2:0]  ready_v, dq_oe_v, ce_n_v, oe_n_v, we_n_v;
  logic [59:0] saddr_v;
  logic [23:0] d2f_v, dqo_v;

`ifdef SRAM_CTRL_B2B_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] ref_mem [int];

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int W = (k == 0) ? 2 : ((k == 1) ? 1 : 4);
    logic        rdy, ce, oen, wen, oe;
    logic [7:0]  d2f, dqo;
    logic [7:0]  dq_i = 8'h00;
    logic [19:0] sa;
    logic [7:0]  cells [int];

    sram_ctrl #(.WAIT_CYC(W)) u_dut (
      .clk(clk), .rst(rst), .mem(mem_v[k]), .rw(rw), .addr(addr), .data2ram(data2ram),
      .ready(rdy), .data2fpga(d2f), .sram_addr(sa), .sram_dq_o(dqo), .sram_dq_i(dq_i),
      .sram_dq_oe(oe), .sram_ce_n(ce), .sram_oe_n(oen), .sram_we_n(wen)
    );

    assign ready_v[k]          = rdy;
    assign dq_oe_v[k]          = oe;
    assign ce_n_v[k]           = ce;
    assign oe_n_v[k]           = oen;
    assign we_n_v[k]           = wen;
    assign saddr_v[k*20 +: 20] = sa;
    assign d2f_v[k*8 +: 8]     = d2f;
    assign dqo_v[k*8 +: 8]     = dqo;

    // SRAM model; address 1 powers up holding 8'hC3
    always @(negedge clk) begin
      if (!ce && !wen && oe) cells[int'(sa)] = dqo;
      if (!ce && !oen && !oe)
        dq_i <= cells.exists(int'(sa)) ? cells[int'(sa)] : ((sa == 20'h1) ? 8'hC3 : 8'h00);
      else
        dq_i <= 8'hxx;
    end
  end

  function automatic int wait_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
  endfunction

  function automatic logic [7:0] ref_rd(input int k, input logic [19:0] a);
    int key;
    key = (k << 20) | int'(a);
    if (ref_mem.exists(key)) return ref_mem[key];
    return (a == 20'h1) ? 8'hC3 : 8'h00;
  endfunction

  // One complete access on instance k, starting from idle; checks timing, pins and read data.
  task automatic access(input int k, input bit is_rd, input logic [19:0] a, input logic [7:0] d,
                        input int pulse_at, input string tag);
    int w, active, rlow, wlow, olow, bad, cyc, extra, exp_act, exp_rlow;
    bit done;
    logic [7:0] exp_d;
    w = wait_of(k);
    active = 0; rlow = 0; wlow = 0; olow = 0; bad = 0; cyc = 0; extra = 0; done = 0;
    exp_d = ref_rd(k, a);
    exp_act  = is_rd ? w : w + 2;
    exp_rlow = is_rd ? (B2B ? w - 1 : w) : (B2B ? w + 1 : w + 2);
    mem_v[k] = 1'b1; rw = is_rd; addr = a; data2ram = d;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      mem_v[k] = 1'b0; addr = a;
      if (ce_n_v[k]) begin
        done = 1;
      end else begin
        active++;
        if (!ready_v[k]) rlow++;
        if (!we_n_v[k]) wlow++;
        if (!oe_n_v[k]) olow++;
        if (saddr_v[k*20 +: 20] !== a) bad++;
        if (dq_oe_v[k] && !oe_n_v[k]) bad++;
        if (is_rd) begin
          if (dq_oe_v[k] !== 1'b0 || we_n_v[k] !== 1'b1) bad++;
        end else begin
          if (dq_oe_v[k] !== 1'b1 || oe_n_v[k] !== 1'b1 || dqo_v[k*8 +: 8] !== d) bad++;
        end
        if (active == pulse_at) begin
          mem_v[k] = 1'b1; rw = 1'b1; addr = ~a;
        end
      end
    end
    checks++;
    if (!done) begin errors++; $display("FAIL %s timeout got %0d cycles want completion", tag, cyc); end
    checks++;
    if (active != exp_act) begin errors++; $display("FAIL %s active_cycles got %0d want %0d", tag, active, exp_act); end
    checks++;
    if (rlow != exp_rlow) begin errors++; $display("FAIL %s ready_low got %0d want %0d", tag, rlow, exp_rlow); end
    checks++;
    if (wlow != (is_rd ? 0 : w)) begin errors++; $display("FAIL %s we_low got %0d want %0d", tag, wlow, is_rd ? 0 : w); end
    checks++;
    if (olow != (is_rd ? w : 0)) begin errors++; $display("FAIL %s oe_low got %0d want %0d", tag, olow, is_rd ? w : 0); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL %s pin_faults got %0d want 0", tag, bad); end
    checks++;
    if (ready_v[k] !== 1'b1) begin errors++; $display("FAIL %s ready_after got %b want 1", tag, ready_v[k]); end
    if (is_rd) begin
      checks++;
      if (d2f_v[k*8 +: 8] !== exp_d) begin
        errors++; $display("FAIL %s data2fpga got %h want %h", tag, d2f_v[k*8 +: 8], exp_d);
      end
    end else begin
      ref_mem[(k << 20) | int'(a)] = d;
    end
    if (pulse_at > 0) begin
      repeat (3) begin
        @(negedge clk);
        if (!ce_n_v[k]) extra++;
      end
      checks++;
      if (extra != 0) begin errors++; $display("FAIL %s extra_access got %0d want 0", tag, extra); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (ready_v !== 3'b111) begin errors++; $display("FAIL reset_ready got %b want 111", ready_v); end
    checks++;
    if (ce_n_v !== 3'b111 || oe_n_v !== 3'b111 || we_n_v !== 3'b111) begin
      errors++; $display("FAIL reset_strobes got ce %b oe %b we %b want 111", ce_n_v, oe_n_v, we_n_v);
    end
    checks++;
    if (dq_oe_v !== 3'b000) begin errors++; $display("FAIL reset_dq_oe got %b want 000", dq_oe_v); end
    checks++;
    if (saddr_v !== 60'd0 || dqo_v !== 24'd0 || d2f_v !== 24'd0) begin
      errors++; $display("FAIL reset_buses got addr %h dq %h d2f %h want 0", saddr_v, dqo_v, d2f_v);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    access(0, 1'b0, 20'hABCDE, 8'h5A, 0, "single_write");
  endtask

  task automatic test_single_read();
    access(0, 1'b1, 20'h00001, 8'h00, 0, "single_read");
    access(0, 1'b0, 20'h00002, 8'h11, 0, "write_after_read");
    checks++;
    if (d2f_v[7:0] !== 8'hC3) begin errors++; $display("FAIL read_hold got %h want c3", d2f_v[7:0]); end
  endtask

  task automatic test_ignored_request();
    access(0, 1'b0, 20'h12345, 8'hE7, 1, "ignored_req");
    access(0, 1'b1, 20'h12345, 8'h00, 0, "ignored_readback");
  endtask

  task automatic test_back_to_back();
    logic [19:0] ra [3];
    logic        rr [3];
    logic [7:0]  rd [3];
    string tr, exp_tr;
    int idx, contention;
    bit acc;
    ra[0] = 20'h00001; rr[0] = 1'b1; rd[0] = 8'h00;
    ra[1] = 20'h00300; rr[1] = 1'b0; rd[1] = 8'h96;
    ra[2] = 20'h00300; rr[2] = 1'b1; rd[2] = 8'h00;
    exp_tr = B2B ? "RRTWWWWRRII" : "RRIWWWWIRRI";
    tr = ""; idx = 0; contention = 0;
    mem_v[0] = 1'b1; rw = rr[0]; addr = ra[0]; data2ram = rd[0];
    acc = ready_v[0];
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      if (dq_oe_v[0] && !oe_n_v[0]) contention++;
      if (!ce_n_v[0] && !oe_n_v[0] && !dq_oe_v[0] && we_n_v[0]) tr = {tr, "R"};
      else if (!ce_n_v[0] && oe_n_v[0] && dq_oe_v[0]) tr = {tr, "W"};
      else if (ce_n_v[0] && ready_v[0]) tr = {tr, "I"};
      else if (ce_n_v[0] && !dq_oe_v[0]) tr = {tr, "T"};
      else tr = {tr, "?"};
      if (acc) begin
        idx++;
        if (idx < 3) begin rw = rr[idx]; addr = ra[idx]; data2ram = rd[idx]; end
        else mem_v[0] = 1'b0;
      end
      acc = mem_v[0] && ready_v[0];
    end
    mem_v[0] = 1'b0;
    ref_mem[int'(ra[1])] = rd[1];
    checks++;
    if (tr != exp_tr) begin errors++; $display("FAIL b2b_trace got %s want %s", tr, exp_tr); end
    checks++;
    if (idx != 3) begin errors++; $display("FAIL b2b_accepts got %0d want 3", idx); end
    checks++;
    if (contention != 0) begin errors++; $display("FAIL b2b_contention got %0d want 0", contention); end
    checks++;
    if (d2f_v[7:0] !== 8'h96) begin errors++; $display("FAIL b2b_readback got %h want 96", d2f_v[7:0]); end
  endtask

  task automatic test_walking_ones();
    logic [19:0] a;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 20; i++) begin
        a = 20'h1 << i;
        access(k, 1'b0, a, 8'hFF ^ 8'(i), 0, "walk_write");
      end
      for (int i = 0; i < 20; i++) begin
        a = 20'h1 << i;
        access(k, 1'b1, a, 8'h00, 0, "walk_read");
      end
    end
  endtask

  task automatic test_random();
    int keys[$];
    int key, k;
    logic [19:0] a;
    for (int n = 0; n < 40; n++) begin
      if (keys.size() > 0 && $urandom_range(1, 0) == 1) begin
        key = keys[$urandom_range(keys.size() - 1, 0)];
        access(key >> 20, 1'b1, 20'(key), 8'h00, 0, "rand_read");
      end else begin
        k = $urandom_range(2, 0);
        a = 20'($urandom);
        access(k, 1'b0, a, 8'($urandom), 0, "rand_write");
        keys.push_back((k << 20) | int'(a));
      end
    end
  endtask

  task automatic test_reset_mid_write();
    bit seen;
    access(0, 1'b0, 20'h0F0F0, 8'hA5, 0, "rst_prep_write");
    access(0, 1'b1, 20'h0F0F0, 8'h00, 0, "rst_prep_read");
    seen = 0;
    mem_v[0] = 1'b1; rw = 1'b0; addr = 20'h55555; data2ram = 8'h3C;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      mem_v[0] = 1'b0;
      if (!we_n_v[0]) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL midwrite_pulse got no we_n low want we_n low"); end
    #3 rst = 1'b0;
    #1;
    checks++;
    if (ce_n_v[0] !== 1'b1 || we_n_v[0] !== 1'b1 || oe_n_v[0] !== 1'b1) begin
      errors++; $display("FAIL midwrite_strobes got ce %b we %b oe %b want 1 1 1", ce_n_v[0], we_n_v[0], oe_n_v[0]);
    end
    checks++;
    if (dq_oe_v[0] !== 1'b0 || ready_v[0] !== 1'b1) begin
      errors++; $display("FAIL midwrite_oe_ready got dq_oe %b ready %b want 0 1", dq_oe_v[0], ready_v[0]);
    end
    checks++;
    if (d2f_v[7:0] !== 8'h00) begin errors++; $display("FAIL midwrite_data2fpga got %h want 00", d2f_v[7:0]); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    access(0, 1'b1, 20'h0F0F0, 8'h00, 0, "post_reset_read");
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_ignored_request();
    test_back_to_back();
    test_walking_ones();
    test_random();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
